tp84_video_counter: RTL and testbench

//  Master horizontal/vertical raster counter for the TimePilot84 video board
//  (models the 74LS161 H/V chain). Produces the raw 9-bit H and V counts plus

---
 rtl/tp84_video_counter.sv | 93 +++++++++
 tb/tb_tp84_video_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tp84_video_counter.sv
// Master H/V raster counter for the TimePilot84 video board (74LS161 chain model).
// Produces raw 9-bit counts plus blank, sync, vblank IRQ and field timing.
module tp84_video_counter #(
   parameter logic [8:0] H_START   = 9'd128,
   parameter logic [8:0] V_START   = 9'd248,
   parameter logic [8:0] HBL_END   = 9'd256,
   parameter logic [8:0] HS_START  = 9'd176,
   parameter logic [8:0] HS_END    = 9'd208,
   parameter logic [8:0] VBL_START = 9'd496,
   parameter logic [8:0] VBL_END   = 9'd272,
   parameter logic [8:0] VS_START  = 9'd248,
   parameter logic [8:0] VS_END    = 9'd256
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       pix_cen,
   output logic [8:0] h_cnt,
   output logic [8:0] v_cnt,
   output logic       hblank,
   output logic       vblank,
   output logic       hsync,
   output logic       vsync,
   output logic       vbl_irq,
   output logic       field
);

   logic [8:0] h_nxt;
   logic [8:0] v_nxt;
   logic       field_nxt;
   logic       irq_nxt;

   function automatic logic hblank_of(input logic [8:0] h);
      return h < HBL_END;
   endfunction

   function automatic logic hsync_of(input logic [8:0] h);
      return (h >= HS_START) && (h < HS_END);
   endfunction

   function automatic logic vblank_of(input logic [8:0] v);
      return (v >= VBL_START) || (v < VBL_END);
   endfunction

   function automatic logic vsync_of(input logic [8:0] v);
      return (v >= VS_START) && (v < VS_END);
   endfunction

   // V steps only on the H wrap; the IRQ fires on the edge that lands on VBL_START.
   always_comb begin
      h_nxt     = h_cnt;
      v_nxt     = v_cnt;
      field_nxt = field;
      irq_nxt   = 1'b0;
      if (pix_cen) begin
         if (h_cnt == 9'd511) begin
            h_nxt = H_START;
            if (v_cnt == 9'd511) begin
               v_nxt     = V_START;
               field_nxt = ~field;
            end else begin
               v_nxt = v_cnt + 9'd1;
            end
            irq_nxt = (v_nxt == VBL_START);
         end else begin
            h_nxt = h_cnt + 9'd1;
         end
      end
   end

   // Flags are decoded from the next-state counts so they line up with the counts.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         h_cnt   <= H_START;
         v_cnt   <= V_START;
         field   <= 1'b0;
         vbl_irq <= 1'b0;
         hblank  <= hblank_of(H_START);
         hsync   <= hsync_of(H_START);
         vblank  <= vblank_of(V_START);
         vsync   <= vsync_of(V_START);
      end else begin
         h_cnt   <= h_nxt;
         v_cnt   <= v_nxt;
         field   <= field_nxt;
         vbl_irq <= irq_nxt;
         hblank  <= hblank_of(h_nxt);
         hsync   <= hsync_of(h_nxt);
         vblank  <= vblank_of(v_nxt);
         vsync   <= vsync_of(v_nxt);
      end
   end

endmodule

// File: tb/tb_tp84_video_counter.sv
// Directed bench for tp84_video_counter: a full-size instance plus a shortened
// raster instance (64 px x 24 lines) so frame-level events fit in a short run.
module tb_tp84_video_counter;

   logic       clk;
   logic       reset_n;
   logic       pix_cen;

   logic [8:0] d_h, d_v;
   logic       d_hblank, d_vblank, d_hsync, d_vsync, d_vbl_irq, d_field;
   logic [8:0] c_h, c_v;
   logic       c_hblank, c_vblank, c_hsync, c_vsync, c_vbl_irq, c_field;

   int checks = 0;
   int failures = 0;
   int d_irq_count = 0;
   int c_irq_count = 0;
   int d_hs_count = 0;

   tp84_video_counter dut (
      .clk(clk), .reset_n(reset_n), .pix_cen(pix_cen),
      .h_cnt(d_h), .v_cnt(d_v), .hblank(d_hblank), .vblank(d_vblank),
      .hsync(d_hsync), .vsync(d_vsync), .vbl_irq(d_vbl_irq), .field(d_field)
   );

   tp84_video_counter #(
      .H_START(9'd448), .V_START(9'd488), .HBL_END(9'd480),
      .HS_START(9'd464), .HS_END(9'd472), .VBL_START(9'd496),
      .VBL_END(9'd272), .VS_START(9'd490), .VS_END(9'd492)
   ) dut_s (
      .clk(clk), .reset_n(reset_n), .pix_cen(pix_cen),
      .h_cnt(c_h), .v_cnt(c_v), .hblank(c_hblank), .vblank(c_vblank),
      .hsync(c_hsync), .vsync(c_vsync), .vbl_irq(c_vbl_irq), .field(c_field)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input logic pc, input logic rn);
      @(negedge clk);
      pix_cen = pc;
      reset_n = rn;
      @(posedge clk);
      #1;
      if (d_vbl_irq) d_irq_count++;
      if (c_vbl_irq) c_irq_count++;
      if (d_hsync) d_hs_count++;
   endtask

   task automatic pulse(input int n);
      repeat (n) tick(1'b1, 1'b1);
   endtask

   task automatic do_reset();
      repeat (3) tick(1'b1, 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (d_h !== 9'd128) begin failures++; $display("FAIL reset_h got=%0d exp=128", d_h); end
      checks++; if (d_v !== 9'd248) begin failures++; $display("FAIL reset_v got=%0d exp=248", d_v); end
      checks++; if (d_hblank !== 1'b1) begin failures++; $display("FAIL reset_hblank got=%b exp=1", d_hblank); end
      checks++; if (d_vblank !== 1'b1) begin failures++; $display("FAIL reset_vblank got=%b exp=1", d_vblank); end
      checks++; if (d_hsync !== 1'b0) begin failures++; $display("FAIL reset_hsync got=%b exp=0", d_hsync); end
      checks++; if (d_vsync !== 1'b1) begin failures++; $display("FAIL reset_vsync got=%b exp=1", d_vsync); end
      checks++; if (d_vbl_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", d_vbl_irq); end
      checks++; if (d_field !== 1'b0) begin failures++; $display("FAIL reset_field got=%b exp=0", d_field); end
      checks++; if (c_h !== 9'd448 || c_v !== 9'd488) begin failures++; $display("FAIL reset_short got=%0d/%0d exp=448/488", c_h, c_v); end
   endtask

   task automatic test_h_wrap();
      d_hs_count = 0;
      pulse(383);
      checks++; if (d_h !== 9'd511 || d_v !== 9'd248) begin failures++; $display("FAIL h_end got=%0d/%0d exp=511/248", d_h, d_v); end
      checks++; if (d_hblank !== 1'b0) begin failures++; $display("FAIL h_end_hblank got=%b exp=0", d_hblank); end
      pulse(1);
      checks++; if (d_h !== 9'd128 || d_v !== 9'd249) begin failures++; $display("FAIL h_wrap got=%0d/%0d exp=128/249", d_h, d_v); end
      checks++; if (d_hblank !== 1'b1) begin failures++; $display("FAIL h_wrap_hblank got=%b exp=1", d_hblank); end
      checks++; if (d_hs_count != 32) begin failures++; $display("FAIL hsync_width got=%0d exp=32", d_hs_count); end
   endtask

   task automatic test_stall();
      int bad;
      bad = 0;
      do_reset();
      pulse(172);
      checks++; if (d_h !== 9'd300 || d_v !== 9'd248) begin failures++; $display("FAIL stall_pos got=%0d/%0d exp=300/248", d_h, d_v); end
      for (int i = 0; i < 50; i++) begin
         tick(1'b0, 1'b1);
         if (d_h !== 9'd300 || d_v !== 9'd248 || d_hblank !== 1'b0 || d_vblank !== 1'b1 ||
             d_hsync !== 1'b0 || d_vsync !== 1'b1 || d_vbl_irq !== 1'b0 || d_field !== 1'b0)
            bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); end
      pulse(1);
      checks++; if (d_h !== 9'd301) begin failures++; $display("FAIL stall_resume got=%0d exp=301", d_h); end
   endtask

   task automatic test_vbl_irq();
      do_reset();
      c_irq_count = 0;
      pulse(511);
      checks++; if (c_h !== 9'd511 || c_v !== 9'd495) begin failures++; $display("FAIL pre_vbl got=%0d/%0d exp=511/495", c_h, c_v); end
      checks++; if (c_vblank !== 1'b0 || c_irq_count != 0) begin failures++; $display("FAIL pre_vbl_flags got=%b/%0d exp=0/0", c_vblank, c_irq_count); end
      pulse(1);
      checks++; if (c_h !== 9'd448 || c_v !== 9'd496) begin failures++; $display("FAIL vbl_start got=%0d/%0d exp=448/496", c_h, c_v); end
      checks++; if (c_vblank !== 1'b1) begin failures++; $display("FAIL vbl_start_vblank got=%b exp=1", c_vblank); end
      checks++; if (c_vbl_irq !== 1'b1) begin failures++; $display("FAIL vbl_irq_rise got=%b exp=1", c_vbl_irq); end
      tick(1'b0, 1'b1);
      checks++; if (c_vbl_irq !== 1'b0 || c_h !== 9'd448) begin failures++; $display("FAIL vbl_irq_stall got=%b/%0d exp=0/448", c_vbl_irq, c_h); end
      tick(1'b1, 1'b1);
      checks++; if (c_vbl_irq !== 1'b0 || c_h !== 9'd449) begin failures++; $display("FAIL vbl_irq_next got=%b/%0d exp=0/449", c_vbl_irq, c_h); end
      checks++; if (c_irq_count != 1) begin failures++; $display("FAIL vbl_irq_count got=%0d exp=1", c_irq_count); end
   endtask

   task automatic test_full_frame();
      do_reset();
      c_irq_count = 0;
      pulse(1536);
      checks++; if (c_h !== 9'd448 || c_v !== 9'd488) begin failures++; $display("FAIL frame_pos got=%0d/%0d exp=448/488", c_h, c_v); end
      checks++; if (c_field !== 1'b1) begin failures++; $display("FAIL frame_field got=%b exp=1", c_field); end
      checks++; if (c_irq_count != 1) begin failures++; $display("FAIL frame_irqs got=%0d exp=1", c_irq_count); end
      pulse(1536);
      checks++; if (c_field !== 1'b0 || c_irq_count != 2) begin failures++; $display("FAIL frame2 got=%b/%0d exp=0/2", c_field, c_irq_count); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      d_irq_count = 0;
      pulse(3071);
      checks++; if (d_v !== 9'd255 || d_vsync !== 1'b1) begin failures++; $display("FAIL vsync_last got=%0d/%b exp=255/1", d_v, d_vsync); end
      pulse(1);
      checks++; if (d_v !== 9'd256 || d_vsync !== 1'b0) begin failures++; $display("FAIL vsync_end got=%0d/%b exp=256/0", d_v, d_vsync); end
      pulse(6143);
      checks++; if (d_v !== 9'd271 || d_vblank !== 1'b1) begin failures++; $display("FAIL vblank_last got=%0d/%b exp=271/1", d_v, d_vblank); end
      pulse(1);
      checks++; if (d_v !== 9'd272 || d_vblank !== 1'b0) begin failures++; $display("FAIL vblank_end got=%0d/%b exp=272/0", d_v, d_vblank); end
      pulse(49357);
      checks++; if (d_h !== 9'd333 || d_v !== 9'd400) begin failures++; $display("FAIL mid_pos got=%0d/%0d exp=333/400", d_h, d_v); end
      checks++; if (d_hblank !== 1'b0 || d_vblank !== 1'b0 || d_vsync !== 1'b0) begin failures++; $display("FAIL mid_flags got=%b%b%b exp=000", d_hblank, d_vblank, d_vsync); end
      checks++; if (d_irq_count != 0) begin failures++; $display("FAIL mid_irqs got=%0d exp=0", d_irq_count); end
      tick(1'b1, 1'b0);
      checks++; if (d_h !== 9'd128 || d_v !== 9'd248 || d_field !== 1'b0) begin failures++; $display("FAIL mid_reset_pos got=%0d/%0d/%b exp=128/248/0", d_h, d_v, d_field); end
      checks++; if (d_hblank !== 1'b1 || d_vblank !== 1'b1 || d_hsync !== 1'b0 || d_vsync !== 1'b1 || d_vbl_irq !== 1'b0) begin
         failures++; $display("FAIL mid_reset_flags got=%b%b%b%b%b exp=11010", d_hblank, d_vblank, d_hsync, d_vsync, d_vbl_irq);
      end
      // Reset on the very edge that would have raised the IRQ.
      pulse(511);
      checks++; if (c_h !== 9'd511 || c_v !== 9'd495) begin failures++; $display("FAIL pend_pos got=%0d/%0d exp=511/495", c_h, c_v); end
      tick(1'b1, 1'b0);
      checks++; if (c_vbl_irq !== 1'b0 || c_v !== 9'd488 || c_h !== 9'd448) begin failures++; $display("FAIL pend_reset got=%b/%0d/%0d exp=0/488/448", c_vbl_irq, c_v, c_h); end
      tick(1'b1, 1'b1);
      checks++; if (c_vbl_irq !== 1'b0 || c_h !== 9'd449) begin failures++; $display("FAIL pend_after got=%b/%0d exp=0/449", c_vbl_irq, c_h); end
   endtask

   initial begin
      reset_n = 1'b0;
      pix_cen = 1'b0;
      test_reset();
      test_h_wrap();
      test_stall();
      test_vbl_irq();
      test_full_frame();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
